// File: rtl/led_pattern_seq.sv
// Programmable blink-pattern player. A PATTERN_W-bit on/off pattern is latched
// on LOAD and shifted out MSB-first on LED, one bit per step period. The step
// period is DIV = CLK_HZ/STEP_HZ clock cycles, produced by an internal
// prescaler. Playback is one-shot (DONE pulse at the end) or repeating, and
// can be paused with ENABLE. All outputs are registered.
module led_pattern_seq #(
  parameter int CLK_HZ    = 16000000,
  parameter int STEP_HZ   = 8,
  parameter int PATTERN_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [PATTERN_W-1:0] PATTERN_IN,
  input  logic                 LOAD,
  input  logic                 REPEAT,
  input  logic                 ENABLE,
  output logic                 LED,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int DIV     = CLK_HZ / STEP_HZ;
  localparam int IDX_W   = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(PATTERN_W - 1);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'((DIV > 0) ? DIV - 1 : 0);

  if (DIV < 1) begin : g_div_check
    $error("led_pattern_seq: CLK_HZ/STEP_HZ must be at least 1");
  end

  if (PATTERN_W < 2) begin : g_width_check
    $error("led_pattern_seq: PATTERN_W must be at least 2");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  state_t               state;
  logic [PATTERN_W-1:0] pat;
  logic [IDX_W-1:0]     idx;
  logic [PRESC_W-1:0]   presc;
  logic                 led_q;
  logic                 busy_q;
  logic                 done_q;

  // Playback FSM: LOAD restarts from the MSB and outranks the step tick; the
  // LED register is loaded with the bit that becomes current on each edge so
  // the output never depends combinationally on the inputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      pat    <= '0;
      idx    <= IDX_MAX;
      presc  <= '0;
      led_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (LOAD) begin
        pat    <= PATTERN_IN;
        idx    <= IDX_MAX;
        presc  <= '0;
        state  <= S_PLAY;
        led_q  <= PATTERN_IN[PATTERN_W-1];
        busy_q <= 1'b1;
      end else if (state == S_PLAY && ENABLE) begin
        if (presc == PRESC_MAX) begin
          presc <= '0;
          if (idx != '0) begin
            idx   <= idx - 1'b1;
            led_q <= pat[idx - 1'b1];
          end else if (REPEAT) begin
            idx   <= IDX_MAX;
            led_q <= pat[PATTERN_W-1];
          end else begin
            idx    <= IDX_MAX;
            state  <= S_IDLE;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  assign LED  = led_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with DIV=4, PATTERN_W=8. Outputs are
// sampled 1 time unit after each rising edge; {LED,BUSY,DONE} is compared
// against hand-derived expectations.
module tb_led_pattern_seq;

  localparam int CLK_HZ    = 16;
  localparam int STEP_HZ   = 4;
  localparam int PATTERN_W = 8;

  logic                 CLK;
  logic                 RST_N;
  logic [PATTERN_W-1:0] PATTERN_IN;
  logic                 LOAD;
  logic                 REPEAT;
  logic                 ENABLE;
  logic                 LED;
  logic                 BUSY;
  logic                 DONE;

  int n_vec = 0;
  int n_err = 0;

  // 8'b1011_0001 as displayed, first bit first
  bit seq_b1 [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  led_pattern_seq #(
    .CLK_HZ   (CLK_HZ),
    .STEP_HZ  (STEP_HZ),
    .PATTERN_W(PATTERN_W)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .PATTERN_IN(PATTERN_IN),
    .LOAD      (LOAD),
    .REPEAT    (REPEAT),
    .ENABLE    (ENABLE),
    .LED       (LED),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Pulse LOAD across one edge; returns just after that edge (edge N)
  task automatic load(input logic [PATTERN_W-1:0] p);
    PATTERN_IN = p;
    LOAD       = 1'b1;
    step();
    LOAD       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    RST_N      = 1'b0;
    PATTERN_IN = '0;
    LOAD       = 1'b0;
    REPEAT     = 1'b0;
    ENABLE     = 1'b1;
    step();
    step();
    check("reset_state", {LED, BUSY, DONE}, 3'b000);
    RST_N = 1'b1;

    // 1: idle after reset, no LOAD
    for (int k = 0; k < 100; k++) begin
      step();
      check("t1_idle", {LED, BUSY, DONE}, 3'b000);
    end

    // 2: one-shot 8'hB1
    REPEAT = 1'b0;
    load(8'hB1);
    for (int k = 0; k < 32; k++) begin
      check("t2_play", {LED, BUSY, DONE}, {seq_b1[k/4], 2'b10});
      step();
    end
    check("t2_done", {LED, BUSY, DONE}, 3'b001);
    step();
    check("t2_done_clr", {LED, BUSY, DONE}, 3'b000);
    step();

    // 3: repeating, then REPEAT dropped during the fourth loop
    REPEAT = 1'b1;
    load(8'hB1);
    for (int k = 0; k < 128; k++) begin
      if (k == 106) REPEAT = 1'b0;
      check("t3_loop", {LED, BUSY, DONE}, {seq_b1[(k/4)%8], 2'b10});
      step();
    end
    check("t3_done", {LED, BUSY, DONE}, 3'b001);
    step();
    check("t3_done_clr", {LED, BUSY, DONE}, 3'b000);

    // 4: 10-cycle pause, 2 cycles into bit 5
    load(8'hB1);
    for (int k = 0; k < 42; k++) begin
      int b;
      if (k < 10)      b = k / 4;
      else if (k < 20) b = 2;
      else             b = (k - 10) / 4;
      check("t4_pause", {LED, BUSY, DONE}, {seq_b1[b], 2'b10});
      if (k == 9)  ENABLE = 1'b0;
      if (k == 19) ENABLE = 1'b1;
      step();
    end
    check("t4_done", {LED, BUSY, DONE}, 3'b001);
    step();
    check("t4_done_clr", {LED, BUSY, DONE}, 3'b000);

    // 5: reload 8'hF0 during bit 3 of 8'h0F, then reload on the final tick
    load(8'h0F);
    for (int k = 0; k < 17; k++) begin
      check("t5_old", {LED, BUSY, DONE}, {(k >= 16), 2'b10});
      step();
    end
    load(8'hF0);
    for (int k = 0; k < 32; k++) begin
      check("t5_new", {LED, BUSY, DONE}, {(k < 16), 2'b10});
      if (k == 31) begin
        PATTERN_IN = 8'h0F;
        LOAD       = 1'b1;
      end
      step();
    end
    LOAD = 1'b0;
    check("t5_final_load", {LED, BUSY, DONE}, 3'b010);
    step();
    check("t5_no_done", {LED, BUSY, DONE}, 3'b010);

    // 6: asynchronous reset mid-playback
    load(8'hFF);
    step();
    step();
    check("t6_pre", {LED, BUSY, DONE}, 3'b110);
    #3;
    RST_N = 1'b0;
    #1;
    check("t6_async", {LED, BUSY, DONE}, 3'b000);
    step();
    #3;
    RST_N = 1'b1;
    REPEAT = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("t6_idle", {LED, BUSY, DONE}, 3'b000);
    end
    load(8'h80);
    check("t6_reload", {LED, BUSY, DONE}, 3'b110);
    for (int k = 0; k < 4; k++) step();
    check("t6_bit6", {LED, BUSY, DONE}, 3'b010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
